data_unpacker: RTL and testbench

Receive-side counterpart of the trace data packer. It accepts N-lane packed vectors and re-emits the original blocks of N, M or 1 values, one block per output beat, under per-chain firmware control. It sits downstream of the trace buffer readout, in front of consumers that expect unpacked blocks, and provides ready/valid handshakes on both sides.

---
 rtl/data_unpacker_pkg.sv | 29 ++
 rtl/data_unpacker_fw_table.sv | 57 +++++
 rtl/data_unpacker.sv | 147 ++++++++++++++
 tb/tb_data_unpacker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_unpacker_pkg.sv
// rtl/data_unpacker_pkg.sv - shared firmware mode constants and mode decode for packer/unpacker
//
// Purpose: firmware byte encodings shared by the trace packer and unpacker,
// the unpacker FSM state type, and the mode-to-block-size decode.
// Ports: none (package).
package data_unpacker_pkg;

  localparam logic [7:0] MODE_N   = 8'd0;
  localparam logic [7:0] MODE_M   = 8'd1;
  localparam logic [7:0] MODE_ONE = 8'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UNPACK = 1'b1
  } unpack_state_e;

  // Lanes per block for a firmware byte; 0 means drop mode.
  function automatic int unsigned mode_lanes(input logic [7:0] mode,
                                             input int unsigned n,
                                             input int unsigned m);
    case (mode)
      MODE_N:   return n;
      MODE_M:   return m;
      MODE_ONE: return 1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/data_unpacker_fw_table.sv
// rtl/data_unpacker_fw_table.sv - per-chain firmware register file with auto-increment config writer
//
// Purpose: MAX_CHAINS x 8-bit firmware table. Every cycle whose config_id_i
// matches PERSONAL_CONFIG_ID writes config_data_i at the write pointer, which
// then advances and wraps. Reads are combinational.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   config_id_i/data_i    config bus address and data
//   rd_idx_i / rd_data_o  combinational read port
module chain_firmware_table #(
  parameter int                        MAX_CHAINS         = 4,
  parameter logic [7:0]                PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0]   INITIAL_FIRMWARE   = '0,
  localparam int                       IW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [7:0]    config_id_i,
  input  logic [7:0]    config_data_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0]    fw_q [MAX_CHAINS];
  logic [7:0]    fw_d [MAX_CHAINS];
  logic [IW-1:0] wptr_q, wptr_d;
  logic          wr_en;

  assign wr_en = (config_id_i == PERSONAL_CONFIG_ID);

  always_comb begin
    wptr_d = wptr_q;
    for (int i = 0; i < MAX_CHAINS; i++) begin
      fw_d[i] = (wr_en && wptr_q == IW'(i)) ? config_data_i : fw_q[i];
    end
    if (wr_en) begin
      wptr_d = (wptr_q == IW'(MAX_CHAINS - 1)) ? '0 : wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < MAX_CHAINS; i++) begin
        fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
      end
      wptr_q <= '0;
    end else begin
      for (int i = 0; i < MAX_CHAINS; i++) begin
        fw_q[i] <= fw_d[i];
      end
      wptr_q <= wptr_d;
    end
  end

  assign rd_data_o = fw_q[rd_idx_i];

endmodule

// File: rtl/data_unpacker.sv
// rtl/data_unpacker.sv - re-emits N-lane packed vectors as blocks of N, M or 1 values
//
// Purpose: receive-side unpacker. An accepted vector is right-aligned into a
// shift register and emitted min(L, remaining) lanes per beat, L chosen per
// chain by firmware. Drop-mode vectors are accepted and discarded.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   tracing                     enables new accepts
//   valid_in/ready_out          input handshake
//   eof_in, chainId_in,
//   count_in, vector_in         input vector and its attributes
//   configId, configData        firmware config bus
//   vector_out, lanes_out,
//   valid_out, eof_out/ready_in output beat and handshake
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int                      N                  = 8,
  parameter int                      M                  = 2,
  parameter int                      DATA_WIDTH         = 32,
  parameter int                      MAX_CHAINS         = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE   = '0,
  localparam int                     CW  = $clog2(N + 1),
  localparam int                     CIW = $clog2(MAX_CHAINS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tracing,
  input  logic                           valid_in,
  output logic                           ready_out,
  input  logic                           eof_in,
  input  logic [CIW-1:0]                 chainId_in,
  input  logic [CW-1:0]                  count_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
  input  logic [7:0]                     configId,
  input  logic [7:0]                     configData,
  output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
  output logic [CW-1:0]                  lanes_out,
  output logic                           valid_out,
  output logic                           eof_out,
  input  logic                           ready_in
);

  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  unpack_state_e state_q, state_d;
  vec_t          sreg_q, sreg_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [CW-1:0] l_q, l_d;
  logic          eof_q, eof_d;

  logic [7:0]    fw_mode;
  logic [CW-1:0] in_lanes;
  logic          in_drop;
  logic [CW-1:0] in_count;
  vec_t          in_shifted;
  logic [CW-1:0] k;
  logic          is_last;
  logic          taken;
  logic          accept;

  chain_firmware_table #(
    .MAX_CHAINS        (MAX_CHAINS),
    .PERSONAL_CONFIG_ID(PERSONAL_CONFIG_ID),
    .INITIAL_FIRMWARE  (INITIAL_FIRMWARE)
  ) u_fw_table (
    .clk_i        (clk),
    .reset_i      (reset),
    .config_id_i  (configId),
    .config_data_i(configData),
    .rd_idx_i     (chainId_in),
    .rd_data_o    (fw_mode)
  );

  // Input side decode: block size, effective count and right-alignment.
  always_comb begin
    in_lanes = CW'(mode_lanes(fw_mode, N, M));
    in_drop  = (in_lanes == '0);
    in_count = (count_in == '0 || count_in > CW'(N)) ? CW'(N) : count_in;
    if (fw_mode == MODE_N) begin
      in_count = CW'(N);
    end
    // Partial vectors live in the top lanes; move them down to lane 0.
    in_shifted = vector_in >> (DATA_WIDTH * (N - int'(in_count)));
  end

  assign k       = (l_q < rem_q) ? l_q : rem_q;
  assign is_last = (rem_q <= l_q);
  assign taken   = (state_q == ST_UNPACK) && ready_in;

  // Ready on the cycle the final beat leaves, so back-to-back vectors have no bubble.
  assign ready_out = tracing && !reset &&
                     (state_q == ST_IDLE || (ready_in && is_last));
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    l_d     = l_q;
    eof_d   = eof_q;
    if (taken) begin
      sreg_d = sreg_q >> (DATA_WIDTH * int'(l_q));
      rem_d  = rem_q - k;
      if (is_last) begin
        state_d = ST_IDLE;
      end
    end
    // A new accept only happens when idle or as the last beat leaves,
    // so it safely overrides the drain update above.
    if (accept && !in_drop) begin
      state_d = ST_UNPACK;
      sreg_d  = in_shifted;
      rem_d   = in_count;
      l_d     = in_lanes;
      eof_d   = eof_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
      l_q     <= '0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      l_q     <= l_d;
      eof_q   <= eof_d;
    end
  end

  // Outputs come straight from registers; rem_q == 0 in IDLE forces zeros.
  always_comb begin
    valid_out = (state_q == ST_UNPACK);
    lanes_out = k;
    eof_out   = valid_out && eof_q && (rem_q == k);
    for (int i = 0; i < N; i++) begin
      vector_out[i] = (CW'(i) < k) ? sreg_q[i] : '0;
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// tb/tb_data_unpacker.sv - randomized self-checking bench for data_unpacker
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int CW = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    vec_t data;
    int   lanes;
    bit   eof;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          tracing;
  logic          valid_in;
  logic          ready_out;
  logic          eof_in;
  logic [1:0]    chainId_in;
  logic [CW-1:0] count_in;
  vec_t          vector_in;
  logic [7:0]    configId;
  logic [7:0]    configData;
  vec_t          vector_out;
  logic [CW-1:0] lanes_out;
  logic          valid_out;
  logic          eof_out;
  logic          ready_in;

  beat_t      exp_q[$];
  logic [7:0] fw_m [MC];
  int         wptr_m;
  int         total;
  int         bad;
  logic [7:0] cfg_pick [8];

  data_unpacker #(
    .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MC),
    .PERSONAL_CONFIG_ID(8'd0), .INITIAL_FIRMWARE('0)
  ) dut (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in),
    .ready_out(ready_out), .eof_in(eof_in), .chainId_in(chainId_in),
    .count_in(count_in), .vector_in(vector_in), .configId(configId),
    .configData(configData), .vector_out(vector_out), .lanes_out(lanes_out),
    .valid_out(valid_out), .eof_out(eof_out), .ready_in(ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [N*DW-1:0] got,
                           input logic [N*DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mode_l(input logic [7:0] mode);
    case (mode)
      8'd0:    return N;
      8'd1:    return M;
      8'd2:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < MC; i++) fw_m[i] = 8'd0;
    wptr_m = 0;
  endtask

  // Expand the vector presented now into its expected beats.
  task automatic push_vector();
    int         l;
    int         cnt;
    logic [DW-1:0] vals[$];
    l = mode_l(fw_m[chainId_in]);
    if (l == 0) return;
    cnt = int'(count_in);
    if (cnt == 0 || cnt > N || fw_m[chainId_in] == 8'd0) cnt = N;
    for (int j = 0; j < cnt; j++) vals.push_back(vector_in[N - cnt + j]);
    for (int b = 0; b < cnt; b += l) begin
      beat_t bt;
      int    kk;
      kk = (cnt - b < l) ? cnt - b : l;
      bt.data = '0;
      for (int i = 0; i < kk; i++) bt.data[i] = vals[b + i];
      bt.lanes = kk;
      bt.eof   = eof_in && (b + kk == cnt);
      exp_q.push_back(bt);
    end
  endtask

  // Inputs are set just after a negedge; check, advance the model, move on.
  task automatic tick();
    bit    exp_ready;
    bit    acc;
    bit    tk;
    beat_t f;
    #1;
    exp_ready = !reset && tracing &&
                (exp_q.size() == 0 || (ready_in && exp_q.size() == 1));
    f.data = '0;
    f.lanes = 0;
    f.eof = 1'b0;
    if (exp_q.size() != 0) f = exp_q[0];
    check_val("ready_out", {255'd0, ready_out}, {255'd0, exp_ready});
    check_val("valid_out", {255'd0, valid_out}, {255'd0, exp_q.size() != 0});
    check_val("lanes_out", {252'd0, lanes_out}, (N*DW)'(f.lanes));
    check_val("eof_out", {255'd0, eof_out}, {255'd0, f.eof});
    check_val("vector_out", vector_out, f.data);
    if (reset) begin
      model_reset();
    end else begin
      tk  = (exp_q.size() != 0) && ready_in;
      acc = valid_in && exp_ready;
      if (tk) void'(exp_q.pop_front());
      if (acc) push_vector();
      if (configId == 8'd0) begin
        fw_m[wptr_m] = configData;
        wptr_m = (wptr_m + 1) % MC;
      end
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [7:0] d);
    configId   = 8'd0;
    configData = d;
    tick();
    configId   = 8'hAA;
  endtask

  task automatic send_ramp(input logic [1:0] ch, input logic [CW-1:0] cnt);
    valid_in   = 1'b1;
    chainId_in = ch;
    count_in   = cnt;
    for (int i = 0; i < N; i++) vector_in[i] = DW'(10 + i);
    tick();
    valid_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cfg_pick[0] = 8'd0; cfg_pick[1] = 8'd1; cfg_pick[2] = 8'd2; cfg_pick[3] = 8'd0;
    cfg_pick[4] = 8'd1; cfg_pick[5] = 8'd2; cfg_pick[6] = 8'd3; cfg_pick[7] = 8'hFF;
    model_reset();
    reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    eof_in = 1'b0; chainId_in = '0; count_in = '0; vector_in = '0;
    configId = 8'hAA; configData = 8'd0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    tracing = 1'b1;
    tick();

    // Mode 0 full vector, then mode-1/-2 chains via config, with wrap.
    send_ramp(2'd0, 4'd8);
    tick();
    cfg_write(8'h01);
    cfg_write(8'h02);
    cfg_write(8'hFF);
    cfg_write(8'h00);
    eof_in = 1'b1;
    send_ramp(2'd1, 4'd8);
    eof_in = 1'b0;
    repeat (4) tick();
    send_ramp(2'd2, 4'd8);
    tick();
    cfg_write(8'h02);
    send_ramp(2'd0, 4'd8);
    repeat (9) tick();
    send_ramp(2'd0, 4'd3);
    send_ramp(2'd0, 4'd3);
    repeat (4) tick();

    // Reset on the second beat of a mode-2 vector.
    send_ramp(2'd0, 4'd8);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();

    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      tracing    = ($urandom_range(0, 9) != 0);
      valid_in   = ($urandom_range(0, 9) < 7);
      ready_in   = ($urandom_range(0, 3) != 0);
      eof_in     = 1'($urandom_range(0, 1));
      chainId_in = 2'($urandom_range(0, 3));
      count_in   = CW'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) vector_in[i] = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        configId   = 8'd0;
        configData = cfg_pick[$urandom_range(0, 7)];
      end else begin
        configId = 8'($urandom_range(1, 255));
      end
      tick();
    end

    reset = 1'b0; valid_in = 1'b0; ready_in = 1'b1; configId = 8'hAA;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
